// File: rtl/sm_mem_arbiter_pkg.sv
// sm_mem_arbiter_pkg: state encodings, grant ids and counter width shared by the memory arbiter.
package sm_mem_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;
    localparam int   CNT_W   = 8;
endpackage

// File: rtl/sm_wait_counter.sv
// sm_wait_counter: saturating wait-state counter that flags the last cycle allowed before a timeout.
module sm_wait_counter
    import sm_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expired
);
    logic [CNT_W-1:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable && r_count != '1)
            r_count <= r_count + 1'b1;
    end
    assign o_count   = r_count;
    assign o_expired = r_count == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/sm_mem_arbiter.sv
// sm_mem_arbiter: round-robin arbiter sharing one single-port memory between the fetch and data ports,
// with a wait-state timeout that aborts stalled transactions and flags an error.
module sm_mem_arbiter
    import sm_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ireq,
    input  logic [ADDR_W-1:0] i_iaddr,
    output logic              o_iack,
    output logic [DATA_W-1:0] o_irdata,
    output logic              o_ierr,
    input  logic              i_dreq,
    input  logic              i_dwe,
    input  logic [ADDR_W-1:0] i_daddr,
    input  logic [DATA_W-1:0] i_dwdata,
    output logic              o_dack,
    output logic [DATA_W-1:0] o_drdata,
    output logic              o_derr,
    output logic              o_mreq,
    output logic              o_mwe,
    output logic [ADDR_W-1:0] o_maddr,
    output logic [DATA_W-1:0] o_mwdata,
    input  logic              i_mack,
    input  logic [DATA_W-1:0] i_mrdata
);
    arb_state_t        r_state, w_state;
    logic              r_last, w_last;
    logic              r_mreq, w_mreq, r_mwe, w_mwe;
    logic [ADDR_W-1:0] r_maddr, w_maddr;
    logic [DATA_W-1:0] r_mwdata, w_mwdata, r_irdata, w_irdata, r_drdata, w_drdata;
    logic              r_iack, w_iack, r_dack, w_dack, r_ierr, w_ierr, r_derr, w_derr;
    logic              w_i_elig, w_d_elig, w_pick_d, w_gnt_d, w_expired;

    sm_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state == ARB_IDLE),
        .i_enable  (r_state != ARB_IDLE),
        .o_count   (),
        .o_expired (w_expired)
    );

    // A port whose ack is currently pulsing still holds Req, so it must not be re-granted.
    assign w_i_elig = i_ireq & ~r_iack;
    assign w_d_elig = i_dreq & ~r_dack;
    assign w_pick_d = w_d_elig & (~w_i_elig | r_last == GRANT_I);
    assign w_gnt_d  = r_state == ARB_GNT_D;

    always_comb begin
        w_state  = r_state;
        w_last   = r_last;
        w_mreq   = r_mreq;
        w_mwe    = r_mwe;
        w_maddr  = r_maddr;
        w_mwdata = r_mwdata;
        w_irdata = r_irdata;
        w_drdata = r_drdata;
        w_iack   = 1'b0;
        w_dack   = 1'b0;
        w_ierr   = 1'b0;
        w_derr   = 1'b0;
        if (r_state == ARB_IDLE) begin
            if (w_i_elig | w_d_elig) begin
                w_state  = w_pick_d ? ARB_GNT_D : ARB_GNT_I;
                w_last   = w_pick_d ? GRANT_D : GRANT_I;
                w_mreq   = 1'b1;
                w_mwe    = w_pick_d & i_dwe;
                w_maddr  = w_pick_d ? i_daddr : i_iaddr;
                w_mwdata = w_pick_d ? i_dwdata : '0;
            end
        end else if (i_mack | w_expired) begin
            // mAck wins over an expiry landing in the same cycle.
            w_state  = ARB_IDLE;
            w_mreq   = 1'b0;
            w_iack   = ~w_gnt_d;
            w_dack   = w_gnt_d;
            w_ierr   = ~w_gnt_d & ~i_mack;
            w_derr   = w_gnt_d & ~i_mack;
            w_irdata = w_gnt_d ? r_irdata : (i_mack ? i_mrdata : '0);
            w_drdata = w_gnt_d ? ((i_mack & ~r_mwe) ? i_mrdata : '0) : r_drdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_last   <= GRANT_I;
            r_mreq   <= 1'b0;
            r_mwe    <= 1'b0;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_irdata <= '0;
            r_drdata <= '0;
            r_iack   <= 1'b0;
            r_dack   <= 1'b0;
            r_ierr   <= 1'b0;
            r_derr   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_last   <= w_last;
            r_mreq   <= w_mreq;
            r_mwe    <= w_mwe;
            r_maddr  <= w_maddr;
            r_mwdata <= w_mwdata;
            r_irdata <= w_irdata;
            r_drdata <= w_drdata;
            r_iack   <= w_iack;
            r_dack   <= w_dack;
            r_ierr   <= w_ierr;
            r_derr   <= w_derr;
        end
    end

    assign o_mreq   = r_mreq;
    assign o_mwe    = r_mwe;
    assign o_maddr  = r_maddr;
    assign o_mwdata = r_mwdata;
    assign o_iack   = r_iack;
    assign o_ierr   = r_ierr;
    assign o_irdata = r_irdata;
    assign o_dack   = r_dack;
    assign o_derr   = r_derr;
    assign o_drdata = r_drdata;
endmodule

// File: tb/tb_sm_mem_arbiter.sv
// tb_sm_mem_arbiter: directed vector table, hand sequences and randomized traffic against a
// transaction-level model of the arbiter (round-robin grants, memory contents, timeouts).
module tb_sm_mem_arbiter;
    localparam int T = 4;

    logic clk = 1'b0, rst_n = 1'b1;
    logic ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, mack = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
    logic iack, ierr, dack, derr, mreq, mwe;
    logic [31:0] irdata, drdata, maddr, mwdata;

    always #5 clk = ~clk;

    sm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ireq(ireq), .i_iaddr(iaddr), .o_iack(iack), .o_irdata(irdata), .o_ierr(ierr),
        .i_dreq(dreq), .i_dwe(dwe), .i_daddr(daddr), .i_dwdata(dwdata),
        .o_dack(dack), .o_drdata(drdata), .o_derr(derr),
        .o_mreq(mreq), .o_mwe(mwe), .o_maddr(maddr), .o_mwdata(mwdata),
        .i_mack(mack), .i_mrdata(mrdata)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Memory model: unwritten words read back as a fixed function of their address.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    typedef struct {logic err; logic [31:0] rdata;} exp_t;
    exp_t iq[$], dq[$], me;
    int   force_d = 0, d_cur = 0, w_cur = 0;
    logic prev_mreq = 0, prev_iack = 0, prev_dack = 0, last_d = 0, ie, de, who;

    // Monitor + slave: predicts each grant from the round-robin rule, plays a slave with a
    // chosen latency, and scores every ack against the expected outcome.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            iq.delete(); dq.delete();
            prev_mreq = 0; prev_iack = 0; prev_dack = 0; last_d = 0; mack = 0; w_cur = 0;
        end else begin
            if (iack) begin
                if (iq.size() == 0) chk("i_ack_unexpected", 1, 0);
                else begin me = iq.pop_front(); chk("i_err", ierr, me.err); chk("i_rdata", irdata, me.rdata); end
            end
            if (dack) begin
                if (dq.size() == 0) chk("d_ack_unexpected", 1, 0);
                else begin me = dq.pop_front(); chk("d_err", derr, me.err); chk("d_rdata", drdata, me.rdata); end
            end
            if (mreq && !prev_mreq) begin
                ie = ireq & ~prev_iack;
                de = dreq & ~prev_dack;
                if (!ie && !de) chk("grant_spurious", 1, 0);
                who = de & (~ie | ~last_d);
                last_d = who;
                chk("grant_addr", maddr, who ? daddr : iaddr);
                chk("grant_we", 32'(mwe), 32'(who & dwe));
                chk("grant_wdata", mwdata, who ? dwdata : 32'h0);
                d_cur = force_d >= 0 ? force_d : int'($urandom_range(0, 5));
                w_cur = 0;
                me.err = d_cur >= T;
                me.rdata = (me.err || (who && dwe)) ? 32'h0 : mem_rd(maddr);
                if (who) dq.push_back(me); else iq.push_back(me);
            end
            if (mreq) begin
                mack = w_cur == d_cur;
                if (mack && mwe) mem[maddr] = mwdata;
                w_cur++;
            end else
                mack = $urandom_range(0, 7) == 0;
            mrdata = (mack && mreq) ? mem_rd(maddr) : $urandom;
            prev_mreq = mreq; prev_iack = iack; prev_dack = dack;
        end
    end

    task automatic go(input bit ri, input bit rd, input bit we, input logic [31:0] ia,
                      input logic [31:0] da, input logic [31:0] wd, input bit scr,
                      output int li, output int ld, output int mc, output int bad);
        logic [64:0] hold;
        hold = '0;
        @(negedge clk); #1;
        ireq = ri; dreq = rd; dwe = we; iaddr = ia; daddr = da; dwdata = wd;
        li = -1; ld = -1; mc = 0; bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk); #1;
            if (mreq) begin
                if (mc == 0) hold = {mwe, maddr, mwdata};
                else if ({mwe, maddr, mwdata} !== hold) bad++;
                mc++;
                if (scr) begin iaddr = $urandom; daddr = $urandom; dwdata = $urandom; dwe = ~dwe; end
            end
            if (iack && li < 0) begin li = n; ireq = 0; end
            if (dack && ld < 0) begin ld = n; dreq = 0; end
            if ((!ri || li >= 0) && (!rd || ld >= 0)) break;
        end
    endtask

    typedef struct {
        bit is_d; bit we; logic [31:0] addr; logic [31:0] wdata; int d;
        logic exp_err; logic [31:0] exp_rdata; int exp_lat; int exp_mc;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int li, ld, mc, bad, lat, iw, dw;
        tbl[0] = '{0, 0, 32'h10, 32'h0,        0,  0, 32'h24020005, 2, 1};
        tbl[1] = '{1, 1, 32'h40, 32'hDEADBEEF, 3,  0, 32'h0,        5, 4};
        tbl[2] = '{1, 0, 32'h80, 32'h0,        99, 1, 32'h0,        5, 4};
        tbl[3] = '{1, 0, 32'h44, 32'h0,        3,  0, 32'h5A5A0044, 5, 4};
        tbl[4] = '{0, 0, 32'h40, 32'h0,        1,  0, 32'hDEADBEEF, 3, 2};
        tbl[5] = '{1, 0, 32'h10, 32'h0,        2,  0, 32'h24020005, 4, 3};
        mem[32'h10] = 32'h24020005;
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_mreq", 32'(mreq), 0);     chk("rst_mwe", 32'(mwe), 0);
        chk("rst_maddr", maddr, 0);        chk("rst_mwdata", mwdata, 0);
        chk("rst_iack", 32'(iack), 0);     chk("rst_dack", 32'(dack), 0);
        chk("rst_ierr", 32'(ierr), 0);     chk("rst_derr", 32'(derr), 0);
        chk("rst_irdata", irdata, 0);      chk("rst_drdata", drdata, 0);
        @(negedge clk); #1 rst_n = 1;

        force_d = 0;
        go(1, 1, 0, 32'h100, 32'h200, 0, 0, li, ld, mc, bad);
        chk("tie1_d_lat", ld, 2);
        chk("tie1_i_lat", li, 4);

        foreach (tbl[k]) begin
            force_d = tbl[k].d;
            go(!tbl[k].is_d, tbl[k].is_d, tbl[k].we, tbl[k].addr, tbl[k].addr, tbl[k].wdata, 1, li, ld, mc, bad);
            lat = tbl[k].is_d ? ld : li;
            chk($sformatf("vec%0d_lat", k), lat, tbl[k].exp_lat);
            chk($sformatf("vec%0d_mreq_cycles", k), mc, tbl[k].exp_mc);
            chk($sformatf("vec%0d_hold", k), bad, 0);
            chk($sformatf("vec%0d_err", k), 32'(tbl[k].is_d ? derr : ierr), 32'(tbl[k].exp_err));
            chk($sformatf("vec%0d_rdata", k), tbl[k].is_d ? drdata : irdata, tbl[k].exp_rdata);
        end

        force_d = 0;
        go(1, 1, 0, 32'h104, 32'h204, 0, 0, li, ld, mc, bad);
        chk("tie2_i_lat", li, 2);
        chk("tie2_d_lat", ld, 4);

        force_d = 99;
        @(negedge clk); #1 ireq = 1; iaddr = 32'h80;
        repeat (2) @(negedge clk);
        chk("rstmid_pre_mreq", 32'(mreq), 1);
        #2 rst_n = 0;
        #1;
        chk("rstmid_mreq", 32'(mreq), 0);
        chk("rstmid_iack", 32'(iack), 0);
        ireq = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        force_d = 0;
        go(1, 1, 0, 32'h108, 32'h208, 0, 0, li, ld, mc, bad);
        chk("rstmid_tie_d_lat", ld, 2);
        chk("rstmid_tie_i_lat", li, 4);

        force_d = -1;
        iw = 0; dw = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk); #1;
            if (ireq) begin
                if (iack) begin
                    iw = 0;
                    if ($urandom_range(0, 1) == 1) iaddr = 32'($urandom_range(0, 15)) << 2;
                    else ireq = 0;
                end else if (++iw > 40) begin chk("i_starved", iw, 0); iw = 0; end
            end else if ($urandom_range(0, 2) == 0) begin
                ireq = 1; iaddr = 32'($urandom_range(0, 15)) << 2;
            end
            if (dreq) begin
                if (dack) begin
                    dw = 0;
                    if ($urandom_range(0, 1) == 1) begin
                        daddr = 32'($urandom_range(0, 15)) << 2; dwe = 1'($urandom_range(0, 1)); dwdata = $urandom;
                    end else dreq = 0;
                end else if (++dw > 40) begin chk("d_starved", dw, 0); dw = 0; end
            end else if ($urandom_range(0, 2) == 0) begin
                dreq = 1; daddr = 32'($urandom_range(0, 15)) << 2; dwe = 1'($urandom_range(0, 1)); dwdata = $urandom;
            end
        end
        ireq = 0; dreq = 0;
        repeat (20) @(negedge clk);
        chk("i_pending_drained", iq.size(), 0);
        chk("d_pending_drained", dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
